// File: rtl/mult_iter_hs.sv
// mult_iter_hs: iterative shift-add multiplier with valid/ready handshakes.
// Each CALC cycle retires K bits of the multiplier, so one product takes
// N = bw/K cycles. Operands are reduced to magnitudes on accept and the sign
// is reapplied on the final CALC edge.
// Optional feature (macro MULT_ITER_HS_ACC_EN): adds input acc_clr, sampled
// with the operands. With acc_clr = 0 the new product is added to the
// previous result, wrapping modulo 2^(2*bw).
module mult_iter_hs #(
  parameter int bw = 16,
  parameter int K  = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [bw-1:0]   A,
  input  logic [bw-1:0]   B,
  input  logic            signed_mode,
`ifdef MULT_ITER_HS_ACC_EN
  input  logic            acc_clr,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*bw-1:0] out,
  output logic            busy
);

  localparam int N  = bw / K;
  localparam int PW = 2 * bw;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // K must split the multiplier into whole K-bit digits.
  if ((bw % K) != 0) begin : g_bad_k
    $error("mult_iter_hs: K must divide bw");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   mcand_q;     // |A|, shifted left by K each CALC edge
  logic [bw:0]     mplier_q;    // |B|, shifted right by K each CALC edge
  logic [PW-1:0]   acc_q;       // running magnitude of the product
  logic [CW-1:0]   cnt_q;
  logic            sign_q;
  logic [PW-1:0]   out_q;
  logic            out_valid_q;
  logic            in_ready_q;
  logic            busy_q;
`ifdef MULT_ITER_HS_ACC_EN
  logic            acc_clr_q;
`endif

  logic [PW-1:0]   term_d;
  logic [PW-1:0]   sum_d;
  logic [PW-1:0]   prod_d;
  logic [PW-1:0]   out_d;
  logic            last_d;

  // Magnitude of an operand in bw+1 bits so that -2^(bw-1) is representable.
  function automatic logic [bw:0] magnitude(input logic [bw-1:0] x, input logic sm);
    logic [bw:0] ext;
    ext = {sm & x[bw-1], x};
    if (ext[bw]) begin
      magnitude = ~ext + {{bw{1'b0}}, 1'b1};
    end else begin
      magnitude = ext;
    end
  endfunction

  // Datapath for one CALC step and the final signed (optionally accumulated) result.
  always_comb begin
    term_d = mcand_q * PW'(mplier_q[K-1:0]);
    sum_d  = acc_q + term_d;
    last_d = (cnt_q == CW'(N - 1));
    if (sign_q) begin
      prod_d = ~sum_d + PW'(1'b1);
    end else begin
      prod_d = sum_d;
    end
`ifdef MULT_ITER_HS_ACC_EN
    if (acc_clr_q) begin
      out_d = prod_d;
    end else begin
      out_d = out_q + prod_d;
    end
`else
    out_d = prod_d;
`endif
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef MULT_ITER_HS_ACC_EN
      acc_clr_q   <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone marks an accept.
          if (in_valid) begin
            mcand_q    <= PW'(magnitude(A, signed_mode));
            mplier_q   <= magnitude(B, signed_mode);
            sign_q     <= signed_mode & (A[bw-1] ^ B[bw-1]);
            acc_q      <= '0;
            cnt_q      <= '0;
`ifdef MULT_ITER_HS_ACC_EN
            acc_clr_q  <= acc_clr;
`endif
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= CALC;
          end else begin
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        CALC: begin
          acc_q    <= sum_d;
          mcand_q  <= mcand_q << K;
          mplier_q <= mplier_q >> K;
          cnt_q    <= cnt_q + CW'(1'b1);
          // Fixed latency: no early exit even if the multiplier runs out of ones.
          if (last_d) begin
            out_q       <= out_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            state_q     <= CALC;
          end
        end
        DONE: begin
          // Hold the result for as long as the consumer stalls.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            state_q     <= DONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mult_iter_hs.sv
// Scoreboard bench for mult_iter_hs (bw = 16, K = 2, N = 8). Stimulus pushes
// hand-computed products into a queue; a negedge monitor pops and compares
// each time a result handshake is about to happen.
module tb_mult_iter_hs;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        busy;
`ifdef MULT_ITER_HS_ACC_EN
  logic        acc_clr;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  mult_iter_hs #(.bw(16), .K(2)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .signed_mode(signed_mode),
`ifdef MULT_ITER_HS_ACC_EN
    .acc_clr(acc_clr),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: a result is consumed at the next posedge when valid & ready.
  always @(negedge CLK) begin
    if (RESET === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got 0x%0h with no pending expectation", out);
      end else begin
        chk("result", out, exp_q.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 50) chk("timeout_in_ready", in_ready, 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 50) chk("timeout_out_valid", out_valid, 1);
  endtask

  // Issue one operation; operands are scrambled right after accept.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sm,
                       input logic [31:0] e);
    wait_ready();
    A = a; B = b; signed_mode = sm; in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    A = 16'hA5A5; B = 16'h5A5A; signed_mode = ~sm;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sm,
                        input logic [31:0] e);
    issue(a, b, sm, e);
    wait_valid();
    @(posedge CLK); #1;
  endtask

  initial begin
    int n;
    RESET = 1'b0; in_valid = 1'b0; A = 16'h0; B = 16'h0;
    signed_mode = 1'b0; out_ready = 1'b1;
`ifdef MULT_ITER_HS_ACC_EN
    acc_clr = 1'b1;
`endif
    #2 RESET = 1'b1;
    #1;
    chk("rst_out", out, 32'h0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    @(posedge CLK); @(posedge CLK); #1;
    RESET = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Unsigned 3 x 5 with latency measurement.
    A = 16'd3; B = 16'd5; signed_mode = 1'b0; in_valid = 1'b1;
    exp_q.push_back(32'h0000000F);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    chk("calc_busy", busy, 1);
    chk("calc_in_ready", in_ready, 0);
    n = 1;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge CLK); #1;
      if (out_valid !== 1'b1) n++;
    end
    chk("latency", n, 8);
    @(posedge CLK); #1;
    chk("in_ready_after_hs", in_ready, 1);
    chk("out_valid_after_hs", out_valid, 0);
    chk("out_retained", out, 32'h0000000F);

    // Signed and unsigned corners.
    run_op(16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1);
    run_op(16'h8000, 16'h8000, 1'b1, 32'h40000000);
    run_op(16'h7FFF, 16'h8000, 1'b1, 32'hC0008000);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
    run_op(16'hFFFD, 16'h0005, 1'b0, 32'h0004FFF1);
    run_op(16'h0000, 16'h1234, 1'b1, 32'h00000000);

    // Backpressure with unsigned 0xFFFF x 0xFFFF.
    out_ready = 1'b0;
    issue(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2); A = 16'd1; B = 16'd1;
      @(posedge CLK); #1;
      chk("bp_out", out, 32'hFFFE0001);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_busy", busy, 0);
    repeat (3) @(posedge CLK);
    #1;
    chk("bp_no_ghost_op", busy, 0);

    // Reset in the middle of CALC.
    wait_ready();
    A = 16'h1234; B = 16'h5678; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("midrst_out", out, 32'h0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    run_op(16'd7, 16'd9, 1'b0, 32'h0000003F);

    // Back-to-back with in_valid held high throughout.
    wait_ready();
    A = 16'd2; B = 16'd2; signed_mode = 1'b0; in_valid = 1'b1;
    exp_q.push_back(32'h00000004);
    @(posedge CLK); #1;
    A = 16'd4; B = 16'd4;
    exp_q.push_back(32'h00000010);
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("b2b_wait", n, 9);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    chk("b2b_second_accepted", busy, 1);
    wait_valid();
    @(posedge CLK); #1;

`ifdef MULT_ITER_HS_ACC_EN
    acc_clr = 1'b1;
    run_op(16'd10, 16'd10, 1'b0, 32'd100);
    acc_clr = 1'b0;
    run_op(16'd5, 16'd5, 1'b0, 32'd125);
    acc_clr = 1'b1;
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    acc_clr = 1'b0;
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFC0002);
    acc_clr = 1'b1;
`endif

    repeat (3) @(posedge CLK);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_iter_hs.md
Name: mult_iter_hs

Overview:
- Parametrised iterative shift-add multiplier; the next generation of the team's combinational array multiplier.
- Retires K multiplier bits per cycle, which trades latency for area.
- Adds valid/ready handshakes on input and output, and a per-operation signed/unsigned mode.
- Sits between operand-producing datapath stages and result consumers that may stall.

Parameters:
- bw, 16, operand width in bits; result is 2*bw.
- K, 2, multiplier bits retired per CALC cycle; must divide bw, else elaboration error.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- A  input  bw  multiplicand.
- B  input  bw  multiplier.
- signed_mode  input  1  1 = two's-complement operands; 0 = unsigned. Sampled with operands.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out  output  2*bw  product.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (asynchronous, any state, including mid-CALC):
  - state = IDLE, out = 0, out_valid = 0, busy = 0.
  - in_ready = 1 after reset deasserts.
  - Internal accumulator, counter and operand registers cleared.
  - In-flight operation discarded; no partial result appears.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1, busy = 0.
  - Accept edge (in_valid & in_ready): latch |A|, |B|, result sign, mode; clear accumulator; count = 0; go to CALC.
  - Magnitude and sign rules:
    - signed_mode = 1: |X| = two's-complement magnitude held in bw+1 bits, so -2^(bw-1) is handled. Sign = A[msb] ^ B[msb].
    - signed_mode = 0: magnitudes are the raw operands; sign = 0.
- CALC:
  - in_ready = 0, busy = 1.
  - Each edge: accumulator += (|A| * low K bits of multiplier reg) << (K*count); multiplier reg >>= K; count++.
  - Accumulator is 2*bw bits; the true product never overflows it.
  - After N = bw/K CALC edges, the final edge writes out (negated if sign = 1), sets out_valid = 1 and moves to DONE.
  - out_valid is first high N edges after the accept edge.
  - There is no early termination on a zero multiplier; latency is fixed.
- DONE:
  - out_valid = 1, busy = 1, in_ready = 0.
  - out is stable while out_ready = 0; backpressure is unbounded.
  - On out_valid & out_ready edge: out_valid = 0, go to IDLE.
  - out retains its value after the handshake until the next result overwrites it.
- in_valid while busy: ignored; no operand is latched. The producer must hold in_valid until in_ready.
- Throughput: one result per N+2 cycles at best (accept, N CALC, handshake edge returns to IDLE).
- Changing A/B/signed_mode after the accept edge has no effect on the current operation.
- Product truncation never occurs.
- Signed result is the exact 2*bw two's-complement product, e.g. (-2^(bw-1))^2 = 2^(2bw-2).

Optional Feature:
- Macro: MULT_ITER_HS_ACC_EN.
- Defined:
  - Extra input acc_clr (1 bit), sampled on the accept edge.
  - acc_clr = 1: out = product.
  - acc_clr = 0: out = previous out + product, modulo 2^(2*bw); wrap-around is silent with no flag.
  - Reset clears the previous out to 0.
  - Latency and handshake are unchanged.
- Undefined: acc_clr port absent; out = product only.

Test Plan (bw = 16, K = 2, N = 8):
- Unsigned 3 x 5: in_valid=1, A=3, B=5, signed_mode=0, out_ready=1 -> out_valid high exactly 8 edges after the accept edge with out=0x0000000F; in_ready back high 1 edge later.
- Signed corners:
  - -3 x 5 (A=0xFFFD, B=0x0005, signed_mode=1) -> out=0xFFFFFFF1.
  - 0x8000 x 0x8000 signed -> out=0x40000000.
  - 0xFFFF x 0xFFFF unsigned -> out=0xFFFE0001.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> out and out_valid stable; in_ready=0; a new in_valid pulse is ignored.
  - Raise out_ready -> IDLE next edge.
- Reset mid-CALC: assert RESET asynchronously after 3 CALC edges of 0x1234 x 0x5678 -> out=0, out_valid=0, busy=0 immediately. Next operation 7 x 9 -> out=0x0000003F.
- Back-to-back: issue 2 x 2 then 4 x 4, with in_valid held high throughout -> second accepted only when in_ready returns; results 0x4 then 0x10 in order.
- With MULT_ITER_HS_ACC_EN:
  - 10 x 10 (acc_clr=1) -> 100; then 5 x 5 (acc_clr=0) -> 125.
  - 0xFFFF x 0xFFFF unsigned twice (acc_clr=1 then 0) -> 0xFFFC0002 (wrapped).
